// File: rtl/sipo_reg_if.sv
// Port bundle for sipo_reg: serial write strobe and data in, parallel word and ready pulse out.
// wr_en_i acts as a valid with an implicit always-high ready: every bit presented with wr_en_i=1 is taken on that edge.
interface sipo_reg_if #(
    parameter int OUTPUT_BW = 8
);
    localparam int CNT_W = $clog2(OUTPUT_BW);

    logic                 wr_en_i;
    logic                 serial_data_i;
    logic [OUTPUT_BW-1:0] dout_bus_o;
    logic                 data_ready_o;
    logic [CNT_W-1:0]     dbg_bit_cnt_o;

    modport master (
        output wr_en_i,
        output serial_data_i,
        input  dout_bus_o,
        input  data_ready_o,
        input  dbg_bit_cnt_o
    );

    modport slave (
        input  wr_en_i,
        input  serial_data_i,
        output dout_bus_o,
        output data_ready_o,
        output dbg_bit_cnt_o
    );
endinterface

// File: rtl/sipo_reg.sv
// Serial-in parallel-out register: collects OUTPUT_BW serial bits and publishes each
// completed word on a registered bus with a one-cycle ready pulse.
module sipo_reg #(
    parameter int OUTPUT_BW = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    sipo_reg_if.slave  bus
);
    localparam int CNT_W = $clog2(OUTPUT_BW);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OUTPUT_BW - 1);

    logic [OUTPUT_BW-1:0] r_shift;
    logic [CNT_W-1:0]     r_cnt;
    logic [OUTPUT_BW-1:0] r_dout;
    logic                 r_ready;

    logic [OUTPUT_BW-1:0] w_shift_next;
    logic                 w_last;

    // The completed word is taken from the next-shift value so the final bit is included on its own edge.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shift_next = {r_shift[OUTPUT_BW-2:0], bus.serial_data_i};
        end else begin : g_lsb_first
            assign w_shift_next = {bus.serial_data_i, r_shift[OUTPUT_BW-1:1]};
        end
    endgenerate

    assign w_last = bus.wr_en_i && (r_cnt == LAST_CNT);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_dout  <= '0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= w_last;
            if (bus.wr_en_i) begin
                r_shift <= w_shift_next;
                r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
            end
            if (w_last) begin
                r_dout <= w_shift_next;
            end
        end
    end

    assign bus.dout_bus_o    = r_dout;
    assign bus.data_ready_o  = r_ready;
    assign bus.dbg_bit_cnt_o = r_cnt;
endmodule

// File: tb/tb_sipo_reg.sv
// Bench for sipo_reg: one MSB-first and one LSB-first instance share the same serial stimulus,
// each with its own expected-word queue checked against every ready pulse.
module tb_sipo_reg;
    localparam int W = 8;

    logic clk;
    logic reset_i;
    int   cyc;
    int   n_tests;
    int   n_fail;

    sipo_reg_if #(.OUTPUT_BW(W)) if_m ();
    sipo_reg_if #(.OUTPUT_BW(W)) if_l ();

    sipo_reg #(.OUTPUT_BW(W), .MSB_FIRST(1)) dut_m (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (if_m.slave)
    );

    sipo_reg #(.OUTPUT_BW(W), .MSB_FIRST(0)) dut_l (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (if_l.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // scoreboard state
    logic [W-1:0] exp_q_m[$];
    logic [W-1:0] exp_q_l[$];
    int           exp_cyc_q_m[$];
    int           exp_cyc_q_l[$];
    int           m_cnt;
    logic [W-1:0] m_word_m;
    logic [W-1:0] m_word_l;
    logic [W-1:0] m_last_m;
    logic [W-1:0] m_last_l;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // output monitors: every ready pulse must match the front of the expected queue, on the expected cycle
    always @(negedge clk) begin
        if (if_m.data_ready_o === 1'b1) begin
            if (exp_q_m.size() == 0) begin
                check("unexp_pulse_m", 1, 0);
            end else begin
                check("word_m", if_m.dout_bus_o, exp_q_m.pop_front());
                check("pulse_cyc_m", cyc, exp_cyc_q_m.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (if_l.data_ready_o === 1'b1) begin
            if (exp_q_l.size() == 0) begin
                check("unexp_pulse_l", 1, 0);
            end else begin
                check("word_l", if_l.dout_bus_o, exp_q_l.pop_front());
                check("pulse_cyc_l", cyc, exp_cyc_q_l.pop_front());
            end
        end
    end

    // drivers: each is entered just after a falling edge and returns just after the next one
    task automatic drive(input logic en, input logic b);
        if_m.wr_en_i       = en;
        if_m.serial_data_i = b;
        if_l.wr_en_i       = en;
        if_l.serial_data_i = b;
    endtask

    task automatic write_bit(input logic b);
        drive(1'b1, b);
        m_word_m[W-1-m_cnt] = b;
        m_word_l[m_cnt]     = b;
        m_cnt++;
        if (m_cnt == W) begin
            exp_q_m.push_back(m_word_m);
            exp_q_l.push_back(m_word_l);
            exp_cyc_q_m.push_back(cyc + 1);
            exp_cyc_q_l.push_back(cyc + 1);
            m_last_m = m_word_m;
            m_last_l = m_word_l;
            m_cnt    = 0;
            m_word_m = '0;
            m_word_l = '0;
        end
        @(negedge clk);
    endtask

    task automatic write_word(input logic [W-1:0] word, input bit gaps);
        for (int i = W - 1; i >= 0; i--) begin
            write_bit(word[i]);
            if (gaps) idle(1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)));
            @(negedge clk);
            check("idle_rdy_m", if_m.data_ready_o, 0);
            check("idle_rdy_l", if_l.data_ready_o, 0);
            check("idle_cnt_m", if_m.dbg_bit_cnt_o, m_cnt);
            check("idle_cnt_l", if_l.dbg_bit_cnt_o, m_cnt);
            check("idle_dout_m", if_m.dout_bus_o, m_last_m);
            check("idle_dout_l", if_l.dout_bus_o, m_last_l);
        end
    endtask

    // asserts reset mid-way through the low clock phase and checks the outputs clear without an edge
    task automatic apply_reset();
        drive(1'b0, 1'b0);
        #2;
        reset_i = 1'b0;
        #1;
        check("rst_async_dout_m", if_m.dout_bus_o, 0);
        check("rst_async_dout_l", if_l.dout_bus_o, 0);
        check("rst_async_rdy_m", if_m.data_ready_o, 0);
        check("rst_async_cnt_m", if_m.dbg_bit_cnt_o, 0);
        check("rst_async_cnt_l", if_l.dbg_bit_cnt_o, 0);
        drive(1'b1, 1'b1);
        repeat (2) @(negedge clk);
        check("rst_hold_dout_m", if_m.dout_bus_o, 0);
        check("rst_hold_cnt_m", if_m.dbg_bit_cnt_o, 0);
        check("rst_hold_rdy_m", if_m.data_ready_o, 0);
        drive(1'b0, 1'b0);
        reset_i  = 1'b1;
        m_cnt    = 0;
        m_word_m = '0;
        m_word_l = '0;
        m_last_m = '0;
        m_last_l = '0;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        cyc      = 0;
        m_cnt    = 0;
        m_word_m = '0;
        m_word_l = '0;
        m_last_m = '0;
        m_last_l = '0;
        reset_i  = 1'b1;
        drive(1'b0, 1'b0);
        @(negedge clk);
        apply_reset();
        idle(2);

        // alternating pattern with idle gaps: 0xAA MSB-first, 0x55 LSB-first
        write_word(8'hAA, 1'b1);
        check("aa_const_m", if_m.dout_bus_o, 8'hAA);
        check("aa_const_l", if_l.dout_bus_o, 8'h55);
        write_bit(1'b1);
        idle(3);
        check("ninth_dout_m", if_m.dout_bus_o, 8'hAA);
        check("ninth_cnt_m", if_m.dbg_bit_cnt_o, 1);
        for (int i = 0; i < W - 1; i++) write_bit(1'($urandom_range(0, 1)));
        idle(1);

        // back-to-back words with the strobe held high
        write_word(8'hF0, 1'b0);
        write_word(8'h0F, 1'b0);
        idle(1);
        check("f00f_dout_m", if_m.dout_bus_o, 8'h0F);

        // serial data wiggling while the strobe is low
        idle(20);

        // long stall inside a word: 10110011
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
        idle(10);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        idle(1);
        check("b3_dout_m", if_m.dout_bus_o, 8'hB3);
        check("b3_dout_l", if_l.dout_bus_o, 8'hCD);

        // reset in the middle of a word, then a fresh word of ones
        for (int i = 0; i < 5; i++) write_bit(1'($urandom_range(0, 1)));
        m_cnt = 0;
        apply_reset();
        @(negedge clk);
        for (int i = 0; i < W; i++) write_bit(1'b1);
        idle(2);
        check("ff_dout_m", if_m.dout_bus_o, 8'hFF);

        // random words with random stalls
        for (int w = 0; w < 6; w++) begin
            for (int i = 0; i < W; i++) begin
                write_bit(1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        idle(3);

        check("left_q_m", exp_q_m.size(), 0);
        check("left_q_l", exp_q_l.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
